// File: rtl/ap_hs_rr_arbiter_if.sv
// ap_hs_rr_arbiter_if: groups the two ap_vld/ap_ack source streams, the merged
// output stream and the optional statistics counters of ap_hs_rr_arbiter.
// Optional feature macro: ARB_STATS_EN (adds cnt0/cnt1).
// slave  : arbiter side (accepts sources, drives merged output)
// master : environment side (drives sources, consumes merged output)
interface ap_hs_rr_arbiter_if #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned CNT_BITS  = 16
);
    logic [DATA_BITS-1:0] in0_data;
    logic                 in0_vld;
    logic                 in0_ack;
    logic [DATA_BITS-1:0] in1_data;
    logic                 in1_vld;
    logic                 in1_ack;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_src;
    logic                 out_vld;
    logic                 out_ack;
`ifdef ARB_STATS_EN
    logic [CNT_BITS-1:0]  cnt0;
    logic [CNT_BITS-1:0]  cnt1;
`endif

    modport slave (
        input  in0_data, in0_vld, in1_data, in1_vld, out_ack,
        output in0_ack, in1_ack, out_data, out_src, out_vld
`ifdef ARB_STATS_EN
        , output cnt0, cnt1
`endif
    );

    modport master (
        output in0_data, in0_vld, in1_data, in1_vld, out_ack,
        input  in0_ack, in1_ack, out_data, out_src, out_vld
`ifdef ARB_STATS_EN
        , input cnt0, cnt1
`endif
    );
endinterface

// File: rtl/ap_hs_rr_arbiter.sv
// ap_hs_rr_arbiter: two-into-one round-robin arbiter for ap_vld/ap_ack streams
// with a bounded burst length. The merged word is registered once and tagged
// with its source index. All logic on the rising edge of clk_user, synchronous
// active-high reset.
// Optional feature macro: ARB_STATS_EN adds per-source transfer counters
// cnt0/cnt1 (CNT_BITS wide, wrapping). Without it no counter logic exists.
module ap_hs_rr_arbiter #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_BITS  = 16
) (
    input logic              clk_user,
    input logic              reset,
    ap_hs_rr_arbiter_if.slave bus
);

    // Reject illegal configurations at elaboration time.
    if (BURST_LEN < 1 || BURST_LEN > 15 || CNT_BITS < 1 || DATA_BITS < 1) begin : g_bad_param
        $error("ap_hs_rr_arbiter: illegal parameter set");
    end

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_LEN);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_owner;
    logic [3:0]           r_burst_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_src;

    logic                 w_owner_nxt;
    logic [3:0]           w_burst_nxt;
    logic                 w_can_load;
    logic                 w_gnt;
    logic                 w_ack0;
    logic                 w_ack1;
    logic                 w_in_xfer;
    logic                 w_out_xfer;

    // Grant selection: single requester wins; on contention the owner keeps
    // the grant until it has used up its burst allowance.
    always_comb begin
        w_gnt = bus.in1_vld;
        if (bus.in0_vld && bus.in1_vld) begin
            w_gnt = (r_burst_cnt < BURST_LIM) ? r_owner : ~r_owner;
        end
    end

    // A source may transfer only when the output register can take a word;
    // acks are held low while reset is asserted.
    always_comb begin
        w_can_load = (r_state == S_EMPTY) || bus.out_ack;
        w_ack0     = ~reset && w_can_load && bus.in0_vld && ~w_gnt;
        w_ack1     = ~reset && w_can_load && bus.in1_vld &&  w_gnt;
        w_in_xfer  = w_ack0 || w_ack1;
        w_out_xfer = (r_state == S_FULL) && bus.out_ack;
    end

    // Occupancy next state: a load fills (or refills) the register, an
    // unloaded drain empties it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_in_xfer) w_state_nxt = S_FULL;
            S_FULL:  if (!w_in_xfer && w_out_xfer) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Burst bookkeeping: the winner here is w_ack1 (source index). Idle
    // cycles leave owner and count untouched so a burst resumes after a gap.
    always_comb begin
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst_cnt;
        if (w_in_xfer) begin
            if (w_ack1 == r_owner) begin
                w_burst_nxt = (r_burst_cnt < BURST_LIM) ? r_burst_cnt + 4'd1 : BURST_LIM;
            end else begin
                w_owner_nxt = w_ack1;
                w_burst_nxt = 4'd1;
            end
        end
    end

    // State, arbitration history and output register.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_owner     <= 1'b0;
            r_burst_cnt <= '0;
            r_data      <= '0;
            r_src       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_nxt;
            if (w_in_xfer) begin
                r_data <= w_ack1 ? bus.in1_data : bus.in0_data;
                r_src  <= w_ack1;
            end
        end
    end

    assign bus.in0_ack  = w_ack0;
    assign bus.in1_ack  = w_ack1;
    assign bus.out_data = r_data;
    assign bus.out_src  = r_src;
    assign bus.out_vld  = (r_state == S_FULL);

`ifdef ARB_STATS_EN
    logic [CNT_BITS-1:0] r_cnt0;
    logic [CNT_BITS-1:0] r_cnt1;

    // Per-source accepted-transfer counters, wrapping naturally.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_ack0) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_ack1) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign bus.cnt0 = r_cnt0;
    assign bus.cnt1 = r_cnt1;
`endif

endmodule
